// File: rtl/issue_queue_dslot_pkg.sv
// Shared decode/issue types and default sizing for the in-order issue queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package issue_queue_dslot_pkg;

  // Default geometry of the decode-to-issue queue.
  localparam int IQ_DEPTH = 8;
  localparam int IQ_ENQ_W = 2;
  localparam int IQ_DEQ_W = 2;

  // Packed decode payload handed from decode to issue.
  typedef struct packed {
    logic [31:0]  pc;
    logic [31:0]  instr;
    logic [191:0] ctrl;
  } decode_payload_t;

  localparam int IQ_ENTRY_W = $bits(decode_payload_t);

  // One queue slot: payload plus its delay-slot tag (tag in the LSB).
  typedef struct packed {
    decode_payload_t payload;
    logic            dslot;
  } iq_entry_t;

endpackage

// File: rtl/issue_queue_dslot_if.sv
// Decode/issue handshake bundle for the issue queue.
// Latency: n/a (wiring only).
// Backpressure: enq_ready is all-or-nothing for the offered lanes; issue consumes via deq_cnt.
interface issue_queue_dslot_if
  import issue_queue_dslot_pkg::*;
#(
  parameter int DEPTH   = IQ_DEPTH,
  parameter int ENQ_W   = IQ_ENQ_W,
  parameter int DEQ_W   = IQ_DEQ_W,
  parameter int ENTRY_W = IQ_ENTRY_W
);
  localparam int EC_W  = $clog2(ENQ_W + 1);
  localparam int DC_W  = $clog2(DEQ_W + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                            flush;
  logic                            flush_keep_head;
  logic [EC_W-1:0]                 enq_cnt;
  logic [ENQ_W-1:0][ENTRY_W-1:0]   enq_data;
  logic [ENQ_W-1:0]                enq_bj;
  logic                            enq_ready;
  logic [DEQ_W-1:0]                deq_valid;
  logic [DEQ_W-1:0][ENTRY_W-1:0]   deq_data;
  logic [DEQ_W-1:0]                deq_dslot;
  logic [DC_W-1:0]                 deq_cnt;
  logic [CNT_W-1:0]                count;
  logic                            empty;

  // Decode/issue side drives the offer, the consume count and the flush.
  modport master (
    output flush, flush_keep_head, enq_cnt, enq_data, enq_bj, deq_cnt,
    input  enq_ready, deq_valid, deq_data, deq_dslot, count, empty
  );

  // The queue itself.
  modport slave (
    input  flush, flush_keep_head, enq_cnt, enq_data, enq_bj, deq_cnt,
    output enq_ready, deq_valid, deq_data, deq_dslot, count, empty
  );

endinterface

// File: rtl/issue_queue_dslot_storage.sv
// Entry array for the issue queue: ENQ_W write ports, DEQ_W combinational read ports.
// Latency: write visible on the read ports the cycle after the write edge.
// Backpressure: none; the caller guarantees writes only target free slots.
module iq_storage #(
  parameter int DEPTH   = 8,
  parameter int ENQ_W   = 2,
  parameter int DEQ_W   = 2,
  parameter int ENTRY_W = 256,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic [ENQ_W-1:0]                i_wr_en,
  input  logic [ENQ_W-1:0][PTR_W-1:0]     i_wr_addr,
  input  logic [ENQ_W-1:0][ENTRY_W:0]     i_wr_dat,
  input  logic [DEQ_W-1:0][PTR_W-1:0]     i_rd_addr,
  output logic [DEQ_W-1:0][ENTRY_W:0]     o_rd_dat
);

  logic [ENTRY_W:0] r_mem [DEPTH];

  // Lane writes; accepted lanes always target distinct free slots, and contents need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (i_wr_en[i]) r_mem[i_wr_addr[i]] <= i_wr_dat[i];
    end
  end

  for (genvar j = 0; j < DEQ_W; j++) begin : g_rd
    assign o_rd_dat[j] = r_mem[i_rd_addr[j]];
  end

endmodule

// File: rtl/issue_queue_dslot.sv
// In-order decode-to-issue queue that tags each entry with its branch delay-slot status.
// Latency: an enqueued entry is visible to issue on the following cycle.
// Backpressure: enq_ready (from start-of-cycle occupancy) accepts all offered lanes or none.
module issue_queue_dslot
  import issue_queue_dslot_pkg::*;
#(
  parameter int DEPTH   = IQ_DEPTH,
  parameter int ENQ_W   = IQ_ENQ_W,
  parameter int DEQ_W   = IQ_DEQ_W,
  parameter int ENTRY_W = IQ_ENTRY_W
) (
  input  logic               clk,
  input  logic               reset,
  issue_queue_dslot_if.slave iq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int EC_W  = $clog2(ENQ_W + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH < ENQ_W || DEPTH < DEQ_W) begin : g_bad_depth
    $error("issue_queue_dslot: DEPTH must be a power of two and at least max(ENQ_W, DEQ_W)");
  end

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_last_bj;

  logic             w_enq_ready;
  logic             w_enq_fire;
  logic [CNT_W-1:0] w_enq_n;
  logic [CNT_W-1:0] w_deq_req;
  logic [CNT_W-1:0] w_deq_eff;
  logic             w_keep;
  logic             w_last_bj_nxt;

  logic [ENQ_W-1:0]              w_wr_en;
  logic [ENQ_W-1:0][PTR_W-1:0]   w_wr_addr;
  logic [ENQ_W-1:0][ENTRY_W:0]   w_wr_dat;
  logic [DEQ_W-1:0][PTR_W-1:0]   w_rd_addr;
  logic [DEQ_W-1:0][ENTRY_W:0]   w_rd_dat;

  // Room for a full-width offer, judged only on start-of-cycle occupancy.
  assign w_enq_ready = (r_count <= CNT_W'(DEPTH - ENQ_W));
  assign w_enq_fire  = w_enq_ready && (iq.enq_cnt != '0) && !iq.flush;
  assign w_enq_n     = w_enq_fire ? CNT_W'(iq.enq_cnt) : '0;

  // Issue may ask for more than is valid; clamp so the head never passes the tail.
  assign w_deq_req = CNT_W'(iq.deq_cnt);
  assign w_deq_eff = iq.flush ? '0 : ((w_deq_req > r_count) ? r_count : w_deq_req);

  // A keep-head flush only preserves something when the head is actually valid.
  assign w_keep = iq.flush_keep_head && (r_count != '0);

  // Lane 0 inherits the branch seen at the end of the previous accepted offer;
  // later lanes inherit from the lane just before them.
  for (genvar i = 0; i < ENQ_W; i++) begin : g_wr
    assign w_wr_en[i]   = w_enq_fire && (EC_W'(i) < iq.enq_cnt);
    assign w_wr_addr[i] = r_tail + PTR_W'(i);
    if (i == 0) begin : g_lane0
      assign w_wr_dat[i] = {iq.enq_data[i], r_last_bj};
    end else begin : g_laneN
      assign w_wr_dat[i] = {iq.enq_data[i], iq.enq_bj[i-1]};
    end
  end

  // Branch status of the youngest offered lane, carried into the next offer.
  always_comb begin
    w_last_bj_nxt = r_last_bj;
    for (int i = 0; i < ENQ_W; i++) begin
      if (iq.enq_cnt == EC_W'(i + 1)) w_last_bj_nxt = iq.enq_bj[i];
    end
  end

  // Pointer, occupancy and branch-history state; flush overrides enqueue and dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_last_bj <= 1'b0;
    end else if (iq.flush) begin
      r_last_bj <= 1'b0;
      if (w_keep) begin
        r_count <= CNT_W'(1);
        r_tail  <= r_head + PTR_W'(1);
      end else begin
        r_count <= '0;
        r_tail  <= r_head;
      end
    end else begin
      r_head  <= r_head + PTR_W'(w_deq_eff);
      r_tail  <= r_tail + PTR_W'(w_enq_n);
      r_count <= r_count + w_enq_n - w_deq_eff;
      if (w_enq_fire) r_last_bj <= w_last_bj_nxt;
    end
  end

  iq_storage #(
    .DEPTH   (DEPTH),
    .ENQ_W   (ENQ_W),
    .DEQ_W   (DEQ_W),
    .ENTRY_W (ENTRY_W),
    .PTR_W   (PTR_W)
  ) u_storage (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_dat  (w_wr_dat),
    .i_rd_addr (w_rd_addr),
    .o_rd_dat  (w_rd_dat)
  );

  // Head-relative read lanes; the dslot tag is masked so stale storage never leaks out.
  for (genvar j = 0; j < DEQ_W; j++) begin : g_rd
    assign w_rd_addr[j]    = r_head + PTR_W'(j);
    assign iq.deq_valid[j] = (CNT_W'(j) < r_count);
    assign iq.deq_data[j]  = w_rd_dat[j][ENTRY_W:1];
    assign iq.deq_dslot[j] = iq.deq_valid[j] & w_rd_dat[j][0];
  end

  assign iq.enq_ready = w_enq_ready;
  assign iq.count     = r_count;
  assign iq.empty     = (r_count == '0);

endmodule

// File: tb/tb_issue_queue_dslot.sv
// Self-checking bench for issue_queue_dslot against a queue-based reference model.
// Latency: model state is compared 1 time unit after each active clock edge.
// Backpressure: model applies all-or-nothing acceptance from start-of-cycle occupancy.
module tb_issue_queue_dslot;
  import issue_queue_dslot_pkg::*;

  localparam int DEPTH   = 8;
  localparam int ENQ_W   = 2;
  localparam int DEQ_W   = 2;
  localparam int ENTRY_W = IQ_ENTRY_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  issue_queue_dslot_if #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .ENTRY_W(ENTRY_W)) iq ();

  issue_queue_dslot #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .ENTRY_W(ENTRY_W)) dut (
    .clk   (clk),
    .reset (reset),
    .iq    (iq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: plain FIFO of (payload, dslot) plus branch history.
  logic [ENTRY_W-1:0] m_d[$];
  logic               m_s[$];
  logic               m_last = 1'b0;

  task automatic model_clear();
    m_d.delete();
    m_s.delete();
    m_last = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by the queue rules, then step past the edge.
  task automatic cycle(input int ec, input logic [ENTRY_W-1:0] d0, input logic [ENTRY_W-1:0] d1,
                       input logic [1:0] bj, input int dc, input logic fl, input logic fk);
    int  sz;
    int  deff;
    bit  rdy;
    sz  = m_d.size();
    rdy = (DEPTH - sz) >= ENQ_W;
    iq.enq_cnt         = 2'(ec);
    iq.enq_data[0]     = d0;
    iq.enq_data[1]     = d1;
    iq.enq_bj          = bj;
    iq.deq_cnt         = 2'(dc);
    iq.flush           = fl;
    iq.flush_keep_head = fk;
    if (fl) begin
      if (fk && sz > 0) begin
        while (m_d.size() > 1) begin
          void'(m_d.pop_back());
          void'(m_s.pop_back());
        end
      end else begin
        m_d.delete();
        m_s.delete();
      end
      m_last = 1'b0;
    end else begin
      deff = (dc < sz) ? dc : sz;
      for (int k = 0; k < deff; k++) begin
        void'(m_d.pop_front());
        void'(m_s.pop_front());
      end
      if (rdy && ec > 0) begin
        m_d.push_back(d0);
        m_s.push_back(m_last);
        if (ec > 1) begin
          m_d.push_back(d1);
          m_s.push_back(bj[0]);
        end
        m_last = bj[ec-1];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, '0, '0, 2'b00, 0, 1'b0, 1'b0);
  endtask

  function automatic logic [ENTRY_W-1:0] rnd_payload();
    logic [ENTRY_W-1:0] v;
    for (int k = 0; k < ENTRY_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 12; k++)
      cycle($urandom_range(0, 2), rnd_payload(), rnd_payload(), 2'($urandom_range(0, 3)),
            $urandom_range(0, 1), 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (iq.count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", iq.count); end
    checks++; if (iq.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", iq.empty); end
    checks++; if (iq.enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got=%b exp=1", iq.enq_ready); end
    checks++; if (iq.deq_valid !== 2'b00) begin errors++; $display("FAIL reset_deq_valid got=%b exp=00", iq.deq_valid); end
    checks++; if (iq.deq_dslot !== 2'b00) begin errors++; $display("FAIL reset_deq_dslot got=%b exp=00", iq.deq_dslot); end
    iq.enq_cnt = '0; iq.deq_cnt = '0; iq.flush = 1'b0; iq.flush_keep_head = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_refuse();
    for (int k = 0; k < 4; k++)
      cycle(2, ENTRY_W'(2*k+1), ENTRY_W'(2*k+2), 2'b00, 0, 1'b0, 1'b0);
    checks++; if (iq.count !== 4'd8) begin errors++; $display("FAIL fill_count got=%0d exp=8", iq.count); end
    checks++; if (iq.enq_ready !== 1'b0) begin errors++; $display("FAIL fill_enq_ready got=%b exp=0", iq.enq_ready); end
    checks++; if (iq.deq_data[0] !== ENTRY_W'(1)) begin errors++; $display("FAIL fill_head got=%0h exp=1", iq.deq_data[0]); end
    cycle(2, ENTRY_W'(100), ENTRY_W'(101), 2'b00, 2, 1'b0, 1'b0);
    checks++; if (iq.count !== 4'd6) begin errors++; $display("FAIL refuse_count got=%0d exp=6", iq.count); end
    checks++; if (iq.deq_data[0] !== ENTRY_W'(3)) begin errors++; $display("FAIL refuse_head got=%0h exp=3", iq.deq_data[0]); end
  endtask

  task automatic test_wrap();
    int exp_seq = 3;
    int next_pl = 9;
    for (int k = 0; k < 20; k++) begin
      checks++; if (iq.deq_data[0] !== ENTRY_W'(exp_seq)) begin errors++; $display("FAIL wrap_lane0 cyc=%0d got=%0h exp=%0h", k, iq.deq_data[0], exp_seq); end
      checks++; if (iq.deq_data[1] !== ENTRY_W'(exp_seq+1)) begin errors++; $display("FAIL wrap_lane1 cyc=%0d got=%0h exp=%0h", k, iq.deq_data[1], exp_seq+1); end
      exp_seq += 2;
      cycle(2, ENTRY_W'(next_pl), ENTRY_W'(next_pl+1), 2'b00, 2, 1'b0, 1'b0);
      next_pl += 2;
      checks++; if (iq.count !== 4'd6) begin errors++; $display("FAIL wrap_count cyc=%0d got=%0d exp=6", k, iq.count); end
    end
  endtask

  task automatic test_dslot();
    cycle(0, '0, '0, 2'b00, 0, 1'b1, 1'b0);
    cycle(2, ENTRY_W'('h11), ENTRY_W'('h12), 2'b10, 0, 1'b0, 1'b0);
    cycle(1, ENTRY_W'('h13), '0, 2'b00, 0, 1'b0, 1'b0);
    checks++; if (iq.deq_dslot !== 2'b00) begin errors++; $display("FAIL dslot_split_first got=%b exp=00", iq.deq_dslot); end
    cycle(0, '0, '0, 2'b00, 2, 1'b0, 1'b0);
    checks++; if (iq.deq_data[0] !== ENTRY_W'('h13)) begin errors++; $display("FAIL dslot_split_data got=%0h exp=13", iq.deq_data[0]); end
    checks++; if (iq.deq_dslot !== 2'b01) begin errors++; $display("FAIL dslot_split_third got=%b exp=01", iq.deq_dslot); end
    cycle(0, '0, '0, 2'b00, 0, 1'b1, 1'b0);
    cycle(2, ENTRY_W'('h21), ENTRY_W'('h22), 2'b01, 0, 1'b0, 1'b0);
    checks++; if (iq.deq_dslot !== 2'b10) begin errors++; $display("FAIL dslot_same_cycle got=%b exp=10", iq.deq_dslot); end
    cycle(0, '0, '0, 2'b00, 0, 1'b1, 1'b0);
    cycle(1, ENTRY_W'('h31), '0, 2'b01, 0, 1'b0, 1'b0);
    idle(3);
    cycle(1, ENTRY_W'('h32), '0, 2'b00, 0, 1'b0, 1'b0);
    checks++; if (iq.deq_dslot !== 2'b10) begin errors++; $display("FAIL dslot_gap got=%b exp=10", iq.deq_dslot); end
    checks++; if (iq.deq_data[1] !== ENTRY_W'('h32)) begin errors++; $display("FAIL dslot_gap_data got=%0h exp=32", iq.deq_data[1]); end
  endtask

  task automatic test_flush();
    cycle(0, '0, '0, 2'b00, 0, 1'b1, 1'b0);
    cycle(1, ENTRY_W'('h1), '0, 2'b01, 0, 1'b0, 1'b0);
    cycle(2, ENTRY_W'('hA), ENTRY_W'('hB), 2'b00, 0, 1'b0, 1'b0);
    cycle(2, ENTRY_W'('hC), ENTRY_W'('hD), 2'b00, 1, 1'b0, 1'b0);
    cycle(1, ENTRY_W'('hE), '0, 2'b00, 0, 1'b0, 1'b0);
    checks++; if (iq.count !== 4'd5) begin errors++; $display("FAIL flush_setup_count got=%0d exp=5", iq.count); end
    checks++; if (iq.deq_data[0] !== ENTRY_W'('hA) || iq.deq_dslot[0] !== 1'b1) begin errors++; $display("FAIL flush_setup_head got=%0h/%b exp=a/1", iq.deq_data[0], iq.deq_dslot[0]); end
    cycle(2, ENTRY_W'('h77), ENTRY_W'('h78), 2'b00, 2, 1'b1, 1'b1);
    checks++; if (iq.count !== 4'd1) begin errors++; $display("FAIL flush_keep_count got=%0d exp=1", iq.count); end
    checks++; if (iq.deq_data[0] !== ENTRY_W'('hA)) begin errors++; $display("FAIL flush_keep_data got=%0h exp=a", iq.deq_data[0]); end
    checks++; if (iq.deq_dslot !== 2'b01) begin errors++; $display("FAIL flush_keep_dslot got=%b exp=01", iq.deq_dslot); end
    checks++; if (iq.deq_valid !== 2'b01) begin errors++; $display("FAIL flush_keep_valid got=%b exp=01", iq.deq_valid); end
    cycle(0, '0, '0, 2'b00, 0, 1'b1, 1'b0);
    checks++; if (iq.count !== 4'd0 || iq.empty !== 1'b1) begin errors++; $display("FAIL flush_all got=%0d/%b exp=0/1", iq.count, iq.empty); end
  endtask

  task automatic test_overdeq();
    cycle(1, ENTRY_W'('h7), '0, 2'b00, 0, 1'b0, 1'b0);
    checks++; if (iq.count !== 4'd1) begin errors++; $display("FAIL overdeq_setup got=%0d exp=1", iq.count); end
    cycle(0, '0, '0, 2'b00, 2, 1'b0, 1'b0);
    checks++; if (iq.count !== 4'd0 || iq.empty !== 1'b1) begin errors++; $display("FAIL overdeq_count got=%0d/%b exp=0/1", iq.count, iq.empty); end
    cycle(1, ENTRY_W'('h5), '0, 2'b00, 0, 1'b0, 1'b0);
    checks++; if (iq.deq_data[0] !== ENTRY_W'('h5)) begin errors++; $display("FAIL overdeq_next got=%0h exp=5", iq.deq_data[0]); end
    checks++; if (iq.count !== 4'd1 || iq.deq_valid !== 2'b01) begin errors++; $display("FAIL overdeq_valid got=%0d/%b exp=1/01", iq.count, iq.deq_valid); end
  endtask

  task automatic test_random();
    logic [1:0] exp_valid;
    logic [1:0] exp_dslot;
    int         sz;
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 2), rnd_payload(), rnd_payload(), 2'($urandom_range(0, 3)),
            $urandom_range(0, 2), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
      sz = m_d.size();
      exp_valid = {sz > 1, sz > 0};
      exp_dslot = {(sz > 1) ? m_s[1] : 1'b0, (sz > 0) ? m_s[0] : 1'b0};
      checks++; if (iq.count !== 4'(sz)) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, iq.count, sz); end
      checks++; if (iq.enq_ready !== ((DEPTH - sz) >= ENQ_W)) begin errors++; $display("FAIL rnd_enq_ready cyc=%0d got=%b size=%0d", k, iq.enq_ready, sz); end
      checks++; if (iq.empty !== (sz == 0)) begin errors++; $display("FAIL rnd_empty cyc=%0d got=%b size=%0d", k, iq.empty, sz); end
      checks++; if (iq.deq_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", k, iq.deq_valid, exp_valid); end
      checks++; if (iq.deq_dslot !== exp_dslot) begin errors++; $display("FAIL rnd_dslot cyc=%0d got=%b exp=%b", k, iq.deq_dslot, exp_dslot); end
      if (sz > 0) begin
        checks++; if (iq.deq_data[0] !== m_d[0]) begin errors++; $display("FAIL rnd_data0 cyc=%0d got=%0h exp=%0h", k, iq.deq_data[0], m_d[0]); end
      end
      if (sz > 1) begin
        checks++; if (iq.deq_data[1] !== m_d[1]) begin errors++; $display("FAIL rnd_data1 cyc=%0d got=%0h exp=%0h", k, iq.deq_data[1], m_d[1]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    iq.flush           = 1'b0;
    iq.flush_keep_head = 1'b0;
    iq.enq_cnt         = '0;
    iq.enq_data        = '0;
    iq.enq_bj          = '0;
    iq.deq_cnt         = '0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    test_reset();
    test_fill_refuse();
    test_wrap();
    test_dslot();
    test_flush();
    test_overdeq();
    test_random();
    test_reset();
    test_overdeq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_queue_dslot.md
Name: issue_queue_dslot

Overview:
- Parametrised in-order queue between decode and issue for the superscalar in-order MIPS core.
- Accepts up to ENQ_W decoded entries per cycle and presents up to DEQ_W oldest entries to issue.
- Tags each entry with its branch delay-slot status, including when the branch and its slot are enqueued in different cycles.
- Supports pipeline flush, optionally preserving the head entry (an in-flight delay slot).

Parameters:
- DEPTH, 8, entry count; power of two and at least max(ENQ_W, DEQ_W); elaboration-time assertion.
- ENQ_W, 2, enqueue lanes per cycle.
- DEQ_W, 2, dequeue lanes per cycle.
- ENTRY_W, 256, payload width in bits (packed decode payload from the shared package).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard queue contents this cycle.
- flush_keep_head  in  1  with flush: keep the current head entry if it is valid.
- enq_cnt  in  $clog2(ENQ_W+1)  number of entries offered, lanes 0..enq_cnt-1.
- enq_data  in  ENQ_W x ENTRY_W  payload per lane; lane 0 is oldest.
- enq_bj  in  ENQ_W  lane holds a branch or jump.
- enq_ready  out  1  queue accepts the whole offer this cycle.
- deq_valid  out  DEQ_W  head lanes hold valid entries; bits are contiguous from lane 0.
- deq_data  out  DEQ_W x ENTRY_W  oldest entries; lane 0 is the head.
- deq_dslot  out  DEQ_W  entry is in a delay slot.
- deq_cnt  in  $clog2(DEQ_W+1)  entries consumed by issue this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- empty  out  1  count==0.

Behaviour:
- Reset (asynchronous):
  - head_ptr=0, tail_ptr=0, count=0, last_bj=0.
  - Outputs: enq_ready=1, deq_valid=0, empty=1, deq_dslot=0.
  - Storage contents are don't-care.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- count is kept separately, so full and empty are unambiguous.
- enq_ready = (DEPTH - count) >= ENQ_W.
  - Computed from start-of-cycle count only; a same-cycle dequeue does not raise it.
  - Combinational from registers only; it does not depend on enq_cnt.
- Enqueue occurs when enq_ready && enq_cnt>0 && !flush.
  - Lane i (i<enq_cnt) is written at tail_ptr+i.
  - tail_ptr advances by enq_cnt.
  - The offer is all-or-nothing.
- Delay-slot tagging, at write time:
  - Lane 0 dslot = last_bj.
  - Lane i>0 dslot = enq_bj[i-1].
  - last_bj updates to enq_bj[enq_cnt-1] on every enqueue with enq_cnt>0.
  - last_bj holds across cycles with no enqueue, so a branch and its slot may be enqueued cycles apart.
- Dequeue side:
  - deq_valid[j] = (j < count).
  - deq_data[j] and deq_dslot[j] are read combinationally from head_ptr+j.
  - An entry becomes visible on the cycle after it is enqueued (1-cycle enqueue-to-visible latency).
  - Dequeue advances head_ptr by min(deq_cnt, count); a deq_cnt larger than the valid count is clamped, never underflows.
- Simultaneous enqueue and dequeue: next count = count + enq_cnt - deq_eff. Both apply; there is no pointer conflict, because enq_ready guarantees free space.
- Flush:
  - Has priority over enqueue and dequeue; both are ignored that cycle.
  - flush && !flush_keep_head, or flush with count==0:
    - count=0, tail_ptr=head_ptr.
    - last_bj=0.
  - flush && flush_keep_head && count>=1:
    - count=1, tail_ptr=head_ptr+1.
    - The head entry keeps its payload and dslot tag.
    - last_bj=0.
- Reset asserted mid-operation returns all state to reset values immediately, regardless of flush, enqueue or dequeue activity.
- Storage is written only on accepted enqueues and is never cleared.

Decomposition:
- Shared package / mips.svh:
  - issue queue entry typedef (payload + dslot bit).
  - Default DEPTH, ENQ_W and DEQ_W constants.
  - ENTRY_W derived from $bits of the decode payload type.
- Sub-module: iq_storage, a DEPTH x (ENTRY_W+1) register array with ENQ_W write ports and DEQ_W combinational read ports, indexed modulo DEPTH.
- The top level holds the pointers, count, last_bj, flush and handshake logic.

Test Plan:
1. Reset with a random prior state -> count=0, empty=1, enq_ready=1, deq_valid=2'b00, deq_dslot=0.
2. DEPTH=8: enq_cnt=2 for 4 cycles with payloads 1..8 -> count=8, enq_ready=0. Then enq_cnt=2 with deq_cnt=2 in the same cycle -> the enqueue is refused and count=6 next cycle.
3. Wrap-around: sustain enq 2 / deq 2 for 20 cycles with payloads incrementing -> dequeued sequence is strictly in order 1,2,3,… across pointer wrap, and count stays constant.
4. Delay slot:
   - enq_bj=2'b10 with enq_cnt=2, next cycle enq_cnt=1 -> the third entry has dslot=1 and the first two have dslot=0.
   - Separately, enq_bj=2'b01 -> lane 1 has dslot=1 in the same cycle.
   - After a branch at the end of an enqueue, 3 idle cycles, then enq_cnt=1 -> that entry has dslot=1.
5. Flush: count=5 with head payload 0xA and dslot=1; assert flush with flush_keep_head=1 and enq_cnt=2 -> count=1, deq_data[0]=0xA, deq_dslot[0]=1, nothing enqueued. A second flush with flush_keep_head=0 -> count=0.
6. Over-dequeue: count=1, deq_cnt=2 -> count=0 next cycle and head_ptr advances by 1 only; a following enqueue of 0x5 appears at deq_data[0].
